control_unit_fsm: RTL and testbench

Multicycle main control FSM for the MIPS datapath. It decodes the 6-bit opcode and sequences fetch, decode, execute, memory and writeback. It drives the 3-bit unitControl code consumed by the ALU control decoder, plus all datapath strobes and mux selects. It sits between the instruction register and the ALU control, register file, memory interface and PC logic.

---
 rtl/control_unit_fsm_if.sv | 64 ++++++
 rtl/control_unit_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_control_unit_fsm.sv | 328 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/control_unit_fsm_if.sv
// Control bundle between the main control FSM and the datapath.
// The FSM side is the master; the datapath side is the slave.
interface control_unit_fsm_if;
  logic [5:0] opcode;
  logic       memReady;
  logic [2:0] unitControl;
  logic       aluSrcA;
  logic [1:0] aluSrcB;
  logic       regDst;
  logic       memToReg;
  logic       regWrite;
  logic       iorD;
  logic       memRead;
  logic       memWrite;
  logic       irWrite;
  logic       pcWrite;
  logic       pcWriteCond;
  logic [1:0] pcSrc;
  logic [3:0] state;
  logic       illegalOp;
  logic       memTimeout;

  modport master (
    input  opcode,
    input  memReady,
    output unitControl,
    output aluSrcA,
    output aluSrcB,
    output regDst,
    output memToReg,
    output regWrite,
    output iorD,
    output memRead,
    output memWrite,
    output irWrite,
    output pcWrite,
    output pcWriteCond,
    output pcSrc,
    output state,
    output illegalOp,
    output memTimeout
  );

  modport slave (
    output opcode,
    output memReady,
    input  unitControl,
    input  aluSrcA,
    input  aluSrcB,
    input  regDst,
    input  memToReg,
    input  regWrite,
    input  iorD,
    input  memRead,
    input  memWrite,
    input  irWrite,
    input  pcWrite,
    input  pcWriteCond,
    input  pcSrc,
    input  state,
    input  illegalOp,
    input  memTimeout
  );
endinterface

// File: rtl/control_unit_fsm.sv
// Multicycle MIPS main control FSM: fetch/decode/execute/mem/writeback
// sequencing with an optional bounded wait on the memory handshake.
module control_unit_fsm #(
  parameter int unsigned WAIT_LIMIT = 0
) (
  input  logic               clk,
  input  logic               reset,
  control_unit_fsm_if.master bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    EXEC_I   = 4'd3,
    MEM_ADDR = 4'd4,
    MEM_RD   = 4'd5,
    MEM_WB   = 4'd6,
    MEM_WR   = 4'd7,
    ALU_WB   = 4'd8,
    BRANCH   = 4'd9,
    JUMP     = 4'd10
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_SLTI = 6'b001010;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;

  localparam bit         HAS_LIM = (WAIT_LIMIT != 0);
  localparam logic [7:0] LIM_M1  = 8'(WAIT_LIMIT - 1);

  state_t     st_q;
  state_t     st_n;
  logic [7:0] cnt_q;
  logic [7:0] cnt_n;
  logic       ill_q;
  logic       ill_n;
  logic       tmo_q;
  logic       tmo_n;

  logic [5:0] op;
  logic       rdy;
  logic       is_r;
  logic       is_i;
  logic       is_mem;
  logic       is_beq;
  logic       is_j;
  logic       waiting;
  logic       lim_hit;

  logic [2:0] uc;
  logic       src_a;
  logic [1:0] src_b;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       reg_wr;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       ir_wr;
  logic       pc_wr;
  logic       pc_wr_cond;
  logic [1:0] pc_src;

  assign op  = bus.opcode;
  assign rdy = bus.memReady;

  assign is_r   = (op == OP_R);
  assign is_i   = (op == OP_ADDI) || (op == OP_ANDI) ||
                  (op == OP_ORI)  || (op == OP_SLTI);
  assign is_mem = (op == OP_LW) || (op == OP_SW);
  assign is_beq = (op == OP_BEQ);
  assign is_j   = (op == OP_J);

  // Only the three handshake states ever stall on memReady.
  assign waiting = !rdy &&
                   ((st_q == FETCH) ||
                    (st_q == MEM_RD) ||
                    (st_q == MEM_WR));
  assign lim_hit = HAS_LIM && waiting &&
                   (cnt_q == LIM_M1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_q  <= FETCH;
      cnt_q <= 8'd0;
      ill_q <= 1'b0;
      tmo_q <= 1'b0;
    end else begin
      st_q  <= st_n;
      cnt_q <= cnt_n;
      ill_q <= ill_n;
      tmo_q <= tmo_n;
    end
  end

  always_comb begin
    st_n       = st_q;
    ill_n      = 1'b0;
    tmo_n      = 1'b0;
    uc         = 3'b000;
    src_a      = 1'b0;
    src_b      = 2'b00;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_wr     = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    ir_wr      = 1'b0;
    pc_wr      = 1'b0;
    pc_wr_cond = 1'b0;
    pc_src     = 2'b00;

    case (st_q)
      FETCH: begin
        mem_rd = 1'b1;
        src_b  = 2'b01;
        uc     = 3'b010;
        if (rdy) begin
          ir_wr = 1'b1;
          pc_wr = 1'b1;
          st_n  = DECODE;
        end else if (lim_hit) begin
          st_n  = FETCH;
          tmo_n = 1'b1;
        end
      end
      DECODE: begin
        src_b = 2'b11;
        uc    = 3'b010;
        unique case (1'b1)
          is_r:    st_n = EXEC_R;
          is_i:    st_n = EXEC_I;
          is_mem:  st_n = MEM_ADDR;
          is_beq:  st_n = BRANCH;
          is_j:    st_n = JUMP;
          default: begin
            st_n  = FETCH;
            ill_n = 1'b1;
          end
        endcase
      end
      EXEC_R: begin
        src_a = 1'b1;
        st_n  = ALU_WB;
      end
      EXEC_I: begin
        src_a = 1'b1;
        src_b = 2'b10;
        case (op)
          OP_ORI:  uc = 3'b001;
          OP_ANDI: uc = 3'b011;
          OP_SLTI: uc = 3'b111;
          default: uc = 3'b010;
        endcase
        st_n = ALU_WB;
      end
      ALU_WB: begin
        reg_wr  = 1'b1;
        reg_dst = is_r;
        st_n    = FETCH;
      end
      MEM_ADDR: begin
        src_a = 1'b1;
        src_b = 2'b10;
        uc    = 3'b010;
        st_n  = (op == OP_LW) ? MEM_RD : MEM_WR;
      end
      MEM_RD: begin
        iord   = 1'b1;
        mem_rd = 1'b1;
        if (rdy) begin
          st_n = MEM_WB;
        end else if (lim_hit) begin
          st_n  = FETCH;
          tmo_n = 1'b1;
        end
      end
      MEM_WB: begin
        reg_wr     = 1'b1;
        mem_to_reg = 1'b1;
        st_n       = FETCH;
      end
      MEM_WR: begin
        iord   = 1'b1;
        mem_wr = 1'b1;
        if (rdy) begin
          st_n = FETCH;
        end else if (lim_hit) begin
          st_n  = FETCH;
          tmo_n = 1'b1;
        end
      end
      BRANCH: begin
        src_a      = 1'b1;
        uc         = 3'b110;
        pc_wr_cond = 1'b1;
        pc_src     = 2'b01;
        st_n       = FETCH;
      end
      JUMP: begin
        pc_wr  = 1'b1;
        pc_src = 2'b10;
        st_n   = FETCH;
      end
      default: st_n = FETCH;
    endcase
  end

  // A timeout re-entering FETCH counts as an entry and clears the count.
  always_comb begin
    cnt_n = cnt_q;
    if ((st_n != st_q) || tmo_n) begin
      cnt_n = 8'd0;
    end else if (waiting && (cnt_q != 8'hff)) begin
      cnt_n = cnt_q + 8'd1;
    end
  end

  // Reset masks every output so nothing fires while it is held.
  assign bus.unitControl = reset ? 3'b000 : uc;
  assign bus.aluSrcA     = !reset && src_a;
  assign bus.aluSrcB     = reset ? 2'b00 : src_b;
  assign bus.regDst      = !reset && reg_dst;
  assign bus.memToReg    = !reset && mem_to_reg;
  assign bus.regWrite    = !reset && reg_wr;
  assign bus.iorD        = !reset && iord;
  assign bus.memRead     = !reset && mem_rd;
  assign bus.memWrite    = !reset && mem_wr;
  assign bus.irWrite     = !reset && ir_wr;
  assign bus.pcWrite     = !reset && pc_wr;
  assign bus.pcWriteCond = !reset && pc_wr_cond;
  assign bus.pcSrc       = reset ? 2'b00 : pc_src;
  assign bus.state       = reset ? 4'd0 : st_q;
  assign bus.illegalOp   = !reset && ill_q;
  assign bus.memTimeout  = !reset && tmo_q;

endmodule

// File: tb/tb_control_unit_fsm.sv
// Bench for control_unit_fsm: two instances (unbounded and 4-cycle
// memory wait) driven by directed then random instruction streams.
module tb_control_unit_fsm;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  control_unit_fsm_if ifa ();
  control_unit_fsm_if ifb ();

  control_unit_fsm #(.WAIT_LIMIT(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifa.master)
  );

  control_unit_fsm #(.WAIT_LIMIT(4)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifb.master)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: each instruction is a route of states after FETCH.
  int         st[2];
  int         wt[2];
  bit         eill[2];
  bit         eto[2];
  int         rt[2][4];
  int         rlen[2];
  int         ridx[2];
  logic [5:0] op[2];
  logic       mr[2];
  int         stall[2];
  int         dir_i[2];
  bit         fresh[2];
  bit         lw_stall;
  bit         did_rst;

  logic [5:0] dirops[8] = '{
    6'b000000, 6'b001101, 6'b001010, 6'b100011,
    6'b101011, 6'b000100, 6'b000010, 6'b111111
  };
  logic [5:0] legal[9] = '{
    6'b000000, 6'b001000, 6'b001100, 6'b001101,
    6'b001010, 6'b100011, 6'b101011, 6'b000100,
    6'b000010
  };

  function automatic int lim(int u);
    return (u == 0) ? 0 : 4;
  endfunction

  function automatic logic [16:0] exp_out(
    int s, logic [5:0] o, logic m);
    logic [2:0] uc   = 3'b000;
    logic       aa   = 1'b0;
    logic [1:0] ab   = 2'b00;
    logic       rd   = 1'b0;
    logic       m2r  = 1'b0;
    logic       rw   = 1'b0;
    logic       iod  = 1'b0;
    logic       mrd  = 1'b0;
    logic       mwr  = 1'b0;
    logic       irw  = 1'b0;
    logic       pcw  = 1'b0;
    logic       pcc  = 1'b0;
    logic [1:0] pcs  = 2'b00;
    case (s)
      0: begin
        uc = 3'b010; ab = 2'b01; mrd = 1'b1;
        irw = m; pcw = m;
      end
      1: begin uc = 3'b010; ab = 2'b11; end
      2: aa = 1'b1;
      3: begin
        aa = 1'b1; ab = 2'b10;
        if (o == 6'b001000) uc = 3'b010;
        else if (o == 6'b001101) uc = 3'b001;
        else if (o == 6'b001100) uc = 3'b011;
        else uc = 3'b111;
      end
      4: begin aa = 1'b1; ab = 2'b10; uc = 3'b010; end
      5: begin iod = 1'b1; mrd = 1'b1; end
      6: begin rw = 1'b1; m2r = 1'b1; end
      7: begin iod = 1'b1; mwr = 1'b1; end
      8: begin rw = 1'b1; rd = (o == 6'b000000); end
      9: begin
        aa = 1'b1; uc = 3'b110;
        pcc = 1'b1; pcs = 2'b01;
      end
      10: begin pcw = 1'b1; pcs = 2'b10; end
      default: ;
    endcase
    return {uc, aa, ab, rd, m2r, rw, iod,
            mrd, mwr, irw, pcw, pcc, pcs};
  endfunction

  task automatic sample(input int u,
                        output logic [16:0] o,
                        output logic [3:0] s,
                        output logic il,
                        output logic tm);
    if (u == 0) begin
      o = {ifa.unitControl, ifa.aluSrcA, ifa.aluSrcB,
           ifa.regDst, ifa.memToReg, ifa.regWrite,
           ifa.iorD, ifa.memRead, ifa.memWrite,
           ifa.irWrite, ifa.pcWrite, ifa.pcWriteCond,
           ifa.pcSrc};
      s = ifa.state; il = ifa.illegalOp; tm = ifa.memTimeout;
    end else begin
      o = {ifb.unitControl, ifb.aluSrcA, ifb.aluSrcB,
           ifb.regDst, ifb.memToReg, ifb.regWrite,
           ifb.iorD, ifb.memRead, ifb.memWrite,
           ifb.irWrite, ifb.pcWrite, ifb.pcWriteCond,
           ifb.pcSrc};
      s = ifb.state; il = ifb.illegalOp; tm = ifb.memTimeout;
    end
  endtask

  task automatic drive(input int u);
    if (u == 0) begin
      ifa.opcode = op[0]; ifa.memReady = mr[0];
    end else begin
      ifb.opcode = op[1]; ifb.memReady = mr[1];
    end
  endtask

  task automatic chk_zero(input int u, input string tag);
    logic [16:0] o;
    logic [3:0]  s;
    logic        il, tm;
    sample(u, o, s, il, tm);
    n_cmp++;
    assert ({o, s, il, tm} === 23'd0) else begin
      n_bad++;
      $error("FAIL %s u%0d: got %h want 0", tag, u,
             {o, s, il, tm});
    end
  endtask

  task automatic check(input int u, input int cyc);
    logic [16:0] o, e;
    logic [3:0]  s;
    logic        il, tm;
    sample(u, o, s, il, tm);
    e = exp_out(st[u], op[u], mr[u]);
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL outs u%0d c%0d st%0d: got %h want %h",
             u, cyc, st[u], o, e);
    end
    n_cmp++;
    assert (s === 4'(st[u])) else begin
      n_bad++;
      $error("FAIL state u%0d c%0d: got %0d want %0d",
             u, cyc, s, st[u]);
    end
    n_cmp++;
    assert (il === eill[u]) else begin
      n_bad++;
      $error("FAIL illegalOp u%0d c%0d: got %b want %b",
             u, cyc, il, eill[u]);
    end
    n_cmp++;
    assert (tm === eto[u]) else begin
      n_bad++;
      $error("FAIL memTimeout u%0d c%0d: got %b want %b",
             u, cyc, tm, eto[u]);
    end
  endtask

  task automatic load_route(input int u);
    case (op[u])
      6'b000000: begin
        rt[u] = '{1, 2, 8, 0}; rlen[u] = 3;
      end
      6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
        rt[u] = '{1, 3, 8, 0}; rlen[u] = 3;
      end
      6'b100011: begin
        rt[u] = '{1, 4, 5, 6}; rlen[u] = 4;
      end
      6'b101011: begin
        rt[u] = '{1, 4, 7, 0}; rlen[u] = 3;
      end
      6'b000100: begin
        rt[u] = '{1, 9, 0, 0}; rlen[u] = 2;
      end
      6'b000010: begin
        rt[u] = '{1, 10, 0, 0}; rlen[u] = 2;
      end
      default: begin
        rt[u] = '{1, 0, 0, 0}; rlen[u] = 1;
      end
    endcase
    ridx[u] = 0;
  endtask

  task automatic step_model(input int u);
    int s = st[u];
    bit ws = (s == 0) || (s == 5) || (s == 7);
    eill[u] = 1'b0;
    eto[u]  = 1'b0;
    if (ws && !mr[u]) begin
      if (lim(u) != 0 && wt[u] == lim(u) - 1) begin
        st[u] = 0; wt[u] = 0;
        eto[u] = 1'b1; fresh[u] = 1'b1;
      end else begin
        wt[u]++;
      end
    end else begin
      if (s == 0) load_route(u);
      if (s == 1 && rlen[u] == 1) eill[u] = 1'b1;
      if (ridx[u] < rlen[u]) begin
        st[u] = rt[u][ridx[u]];
        ridx[u]++;
      end else begin
        st[u] = 0;
      end
      wt[u] = 0;
      if (st[u] == 0) fresh[u] = 1'b1;
    end
  endtask

  function automatic logic [5:0] pick_random();
    logic [5:0] o;
    int k = $urandom_range(0, 9);
    if (k < 9) return legal[k];
    o = 6'($urandom);
    while (o inside {legal}) o = 6'($urandom);
    return o;
  endfunction

  task automatic choose(input int u, input int cyc);
    if (fresh[u]) begin
      fresh[u] = 1'b0;
      if (dir_i[u] < 8) begin
        op[u] = dirops[dir_i[u]];
        dir_i[u]++;
        if (u == 0 && op[u] == 6'b100011) lw_stall = 1'b1;
      end else if (u == 0 && cyc > 150 && !did_rst) begin
        op[u] = 6'b000000;
      end else begin
        op[u] = pick_random();
      end
    end
    if (u == 0 && st[0] == 5 && lw_stall) begin
      lw_stall = 1'b0;
      stall[0] = 3;
    end
    if (cyc < 60) begin
      mr[u] = 1'b1;
      if (stall[u] > 0) begin
        mr[u] = 1'b0;
        stall[u]--;
      end
    end else begin
      mr[u] = ($urandom_range(0, 3) != 0);
    end
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      st[u] = 0; wt[u] = 0; eill[u] = 0; eto[u] = 0;
      fresh[u] = 1'b1; dir_i[u] = 0; stall[u] = 0;
      op[u] = 6'b000000; mr[u] = 1'b1; rlen[u] = 0;
      ridx[u] = 0;
      drive(u);
    end
    stall[1] = 6;
    lw_stall = 1'b0;
    did_rst  = 1'b0;

    #2;
    chk_zero(0, "reset0");
    chk_zero(1, "reset1");
    @(negedge clk);
    chk_zero(0, "reset0b");
    reset = 1'b0;

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int u = 0; u < 2; u++) begin
        choose(u, cyc);
        drive(u);
      end
      #1;
      check(0, cyc);
      check(1, cyc);
      if (cyc > 150 && !did_rst && st[0] == 2) begin
        did_rst = 1'b1;
        reset = 1'b1;
        #1;
        chk_zero(0, "midrst0");
        chk_zero(1, "midrst1");
        @(posedge clk);
        #1;
        chk_zero(0, "midrst0b");
        chk_zero(1, "midrst1b");
        @(negedge clk);
        reset = 1'b0;
        for (int u = 0; u < 2; u++) begin
          st[u] = 0; wt[u] = 0; eill[u] = 0;
          eto[u] = 0; fresh[u] = 1'b1;
        end
        continue;
      end
      step_model(0);
      step_model(1);
      @(negedge clk);
    end

    n_cmp++;
    assert (did_rst) else begin
      n_bad++;
      $error("FAIL midrst_reached: got %b want 1", did_rst);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
